axi_mem_slave: RTL and testbench
================================

// Module: axi_mem_slave
// PURPOSE
//  AXI4 slave responder backed by a word-wide internal SRAM; the memory-side counterpart of the DMA master.
//  Serves AR/R read bursts and AW/W/B write bursts on independent channels.
//  Sits on the m_axi_* bus in block-level and top-level benches.
//  Also usable as on-chip scratch buffer for the FFT accelerator.
// PARAMETERS
//  AXI_ADDR_WIDTH  32                 byte address width
//  AXI_DATA_WIDTH  64                 data bus width (bits), power of 2, >=16
//  AXI_ID_WIDTH    8                  transaction ID width
//  MEM_DEPTH       1024               SRAM depth in AXI_DATA_WIDTH words, power of 2
//  AXI_STRB_WIDTH  AXI_DATA_WIDTH/8   write strobe width
// PORTS
//  clk           in   1      clock
//  rst_n         in   1      async active-low reset
//  s_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read request
//  s_axi_arvalid in 1; s_axi_arready out 1   AR handshake
//  s_axi_rid     out  ID     echoes latched arid
//  s_axi_rdata   out  DATA   read beat data
//  s_axi_rresp   out  2      OKAY(00) / SLVERR(10)
//  s_axi_rlast   out  1      final read beat
//  s_axi_rvalid out 1; s_axi_rready in 1     R handshake
//  s_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write request
//  s_axi_awvalid in 1; s_axi_awready out 1   AW handshake
//  s_axi_wdata in DATA; s_axi_wstrb in STRB; s_axi_wlast in 1  write beat
//  s_axi_wvalid in 1; s_axi_wready out 1     W handshake
//  s_axi_bid out ID; s_axi_bresp out 2       write response
//  s_axi_bvalid out 1; s_axi_bready in 1     B handshake
// BEHAVIOUR
//  Reset: every output 0; FSMs to *_IDLE; SRAM contents not reset. arready/awready rise 1 cycle after rst_n release.
//  Word index = addr[log2(STRB)+:log2(MEM_DEPTH)]; low byte bits ignored; upper bits ignored (wrap modulo MEM_DEPTH).
//  arsize/awsize, arburst/awburst ignored: every burst is full-width INCR, len+1 beats (1..256).
//  Beat address increments by 1 word per beat, wraps MEM_DEPTH-1 -> 0 mid-burst.
//  Read FSM R_IDLE -> R_FETCH -> R_DATA -> R_IDLE:
//   R_IDLE: arready=1; on arvalid&arready latch id, word index, len, beat cnt=0; go R_FETCH.
//   R_FETCH: registered SRAM read of current word; go R_DATA. AR handshake cycle N -> first rvalid at N+2.
//   R_DATA: rvalid=1; rdata/rlast/rid/rresp stable while rvalid&!rready.
//   On rready: if cnt==len -> R_IDLE, else cnt++, addr++, go R_FETCH (max 1 beat / 2 cycles).
//   rlast=1 only when cnt==len.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: awready=1, wready=0; on AW handshake latch id, index, len, cnt=0, err=0; go W_DATA.
//   W_DATA: wready=1; each W handshake writes bytes where wstrb=1, same cycle; addr++, cnt++.
//   Beat terminates on wlast; err set if wlast with cnt!=len, or cnt==len without wlast (extra beats dropped, still acked until wlast).
//   After wlast beat -> W_RESP: bvalid=1, bid=latched id, bresp=err?SLVERR:OKAY; held until bready; then W_IDLE.
//  Read/write concurrent; same-word collision in one cycle: read returns old data, write commits.
//  W beats arriving before AW are not accepted (wready=0 in W_IDLE).
//  rst_n low mid-burst: both FSMs abort immediately, outputs 0, no response for aborted burst.
// CONFIGURATION
//  AXI_MEM_SLAVE_RANGE_CHK_EN defined: upper address bits above SRAM span checked at AR/AW latch.
//   Out-of-range: reads return rdata=0, rresp=SLVERR every beat; writes suppress SRAM update, bresp=SLVERR.
//  Not defined: no range check; upper bits ignored; responses always OKAY except W length mismatch.
// TESTING
//  T1 write addr 0x100 len 3 wstrb FF data 1..4, bready=1 -> 4 beats accepted, bresp=00, bid=awid.
//  T2 read addr 0x100 len 3, rready=1 -> rdata 1,2,3,4; rlast on beat 4 only; first rvalid 2 cycles after AR.
//  T3 read len 7 with rready toggled 0/1 each cycle -> rdata held stable while stalled, 8 beats in order.
//  T4 wstrb=0x0F on word holding all-ones, data 0 -> readback 0xFFFFFFFF_00000000.
//  T5 write len 3 with wlast on beat 2 -> bresp=10; words written by beats 1-2 only.
//  T6 RANGE_CHK_EN, read addr 1<<20 (MEM_DEPTH 1024) -> rresp=10, rdata=0; assert rst_n mid-read -> rvalid=0 next cycle.

Source files
------------

// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a word-wide SRAM; independent read (AR/R) and write (AW/W/B) engines.
// Optional AXI_MEM_SLAVE_RANGE_CHK_EN: flags addresses above the SRAM span as SLVERR.
module axi_mem_slave #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 8,
   parameter int MEM_DEPTH      = 1024,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic [1:0]                s_axi_arburst,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
   output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   output logic [1:0]                dbg_r_state,
   output logic [1:0]                dbg_w_state
);

   localparam int IDX_LSB = $clog2(AXI_STRB_WIDTH);
   localparam int IDX_W   = $clog2(MEM_DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_e;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;

   // Every channel transfers on a cycle where valid and ready are both high at the
   // rising edge; once valid is raised, its payload is held until that transfer.

   logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

   r_state_e                  r_state_q, r_state_d;
   logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic [IDX_W-1:0]          r_idx_q, r_idx_d;
   logic [7:0]                r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic                      r_err_q, r_err_d;
   logic                      arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;

   w_state_e                  w_state_q, w_state_d;
   logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
   logic [IDX_W-1:0]          w_idx_q, w_idx_d;
   logic [7:0]                w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic                      w_err_q, w_err_d, w_oor_q, w_oor_d, w_drop_q, w_drop_d;
   logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [1:0]                bresp_q, bresp_d;
   logic                      mem_we;

   logic ar_oor, aw_oor;
`ifdef AXI_MEM_SLAVE_RANGE_CHK_EN
   assign ar_oor = |s_axi_araddr[AXI_ADDR_WIDTH-1:IDX_LSB+IDX_W];
   assign aw_oor = |s_axi_awaddr[AXI_ADDR_WIDTH-1:IDX_LSB+IDX_W];
`else
   assign ar_oor = 1'b0;
   assign aw_oor = 1'b0;
`endif

   // Size/burst and the non-index address bits do not affect behaviour.
   logic unused_inputs;
   assign unused_inputs = ^{s_axi_araddr[AXI_ADDR_WIDTH-1:IDX_LSB+IDX_W], s_axi_araddr[IDX_LSB-1:0],
                            s_axi_awaddr[AXI_ADDR_WIDTH-1:IDX_LSB+IDX_W], s_axi_awaddr[IDX_LSB-1:0],
                            s_axi_arsize, s_axi_arburst, s_axi_awsize, s_axi_awburst};

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_err_d   = r_err_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (s_axi_arvalid && arready_q) begin
               r_id_d    = s_axi_arid;
               r_idx_d   = s_axi_araddr[IDX_LSB +: IDX_W];
               r_len_d   = s_axi_arlen;
               r_cnt_d   = 8'd0;
               r_err_d   = ar_oor;
               arready_d = 1'b0;
               r_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            rdata_d   = r_err_q ? '0 : mem[r_idx_q];
            rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
            rlast_d   = (r_cnt_q == r_len_q);
            rvalid_d  = 1'b1;
            r_state_d = R_DATA;
         end
         R_DATA: begin
            if (s_axi_rready) begin
               rvalid_d = 1'b0;
               rlast_d  = 1'b0;
               if (r_cnt_q == r_len_q) begin
                  arready_d = 1'b1;
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d   = r_cnt_q + 8'd1;
                  r_idx_d   = r_idx_q + IDX_W'(1);
                  r_state_d = R_FETCH;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      w_oor_d   = w_oor_q;
      w_drop_d  = w_drop_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            wready_d  = 1'b0;
            if (s_axi_awvalid && awready_q) begin
               w_id_d    = s_axi_awid;
               w_idx_d   = s_axi_awaddr[IDX_LSB +: IDX_W];
               w_len_d   = s_axi_awlen;
               w_cnt_d   = 8'd0;
               w_err_d   = 1'b0;
               w_oor_d   = aw_oor;
               w_drop_d  = 1'b0;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (s_axi_wvalid && wready_q) begin
               mem_we = !w_drop_q && !w_oor_q;
               if (s_axi_wlast) begin
                  w_err_d   = w_err_q | (!w_drop_q && (w_cnt_q != w_len_q));
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = (w_err_d || w_oor_q) ? RESP_SLVERR : RESP_OKAY;
                  w_state_d = W_RESP;
               end else begin
                  // Final beat seen without wlast: keep acking, stop writing.
                  if (w_cnt_q == w_len_q) begin
                     w_err_d  = 1'b1;
                     w_drop_d = 1'b1;
                  end
                  w_cnt_d = w_cnt_q + 8'd1;
                  w_idx_d = w_idx_q + IDX_W'(1);
               end
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
            if (s_axi_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_err_q   <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
         w_oor_q   <= 1'b0;
         w_drop_q  <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_err_q   <= r_err_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
         w_oor_q   <= w_oor_d;
         w_drop_q  <= w_drop_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rid     = r_id_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rlast   = rlast_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bid     = w_id_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_bvalid  = bvalid_q;
   assign dbg_r_state   = r_state_q;
   assign dbg_w_state   = w_state_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: drivers push expected R/B responses, a negedge monitor checks them.
module tb_axi_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_axi_arid, s_axi_awid, s_axi_rid, s_axi_bid;
   logic [31:0] s_axi_araddr, s_axi_awaddr;
   logic [7:0]  s_axi_arlen, s_axi_awlen;
   logic [2:0]  s_axi_arsize, s_axi_awsize;
   logic [1:0]  s_axi_arburst, s_axi_awburst;
   logic        s_axi_arvalid, s_axi_arready, s_axi_awvalid, s_axi_awready;
   logic [63:0] s_axi_rdata, s_axi_wdata;
   logic [1:0]  s_axi_rresp, s_axi_bresp;
   logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
   logic [7:0]  s_axi_wstrb;
   logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic        s_axi_bvalid, s_axi_bready;
   logic [1:0]  dbg_r_state, dbg_w_state;

   axi_mem_slave dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          rmode    = 0;  // 0: rready high, 1: toggle, 2: held low
   logic [74:0] exp_r_q[$];    // {id, data, resp, last}
   logic [9:0]  exp_b_q[$];    // {id, resp}
   logic [63:0] wd[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      s_axi_rready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       s_axi_rready = 1'b1;
            1:       s_axi_rready = ~s_axi_rready;
            default: s_axi_rready = 1'b0;
         endcase
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [74:0] er;
      logic [9:0]  eb;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (s_axi_rvalid) begin
               if (exp_r_q.size() == 0) check("r_unexpected_valid", 64'(s_axi_rvalid), 64'd0);
               else begin
                  er = exp_r_q[0];
                  check("rid", 64'(s_axi_rid), 64'(er[74:67]));
                  check("rdata", s_axi_rdata, er[66:3]);
                  check("rresp", 64'(s_axi_rresp), 64'(er[2:1]));
                  check("rlast", 64'(s_axi_rlast), 64'(er[0]));
                  if (s_axi_rready) void'(exp_r_q.pop_front());
               end
            end
            if (s_axi_bvalid) begin
               if (exp_b_q.size() == 0) check("b_unexpected_valid", 64'(s_axi_bvalid), 64'd0);
               else begin
                  eb = exp_b_q[0];
                  check("bid", 64'(s_axi_bid), 64'(eb[9:2]));
                  check("bresp", 64'(s_axi_bresp), 64'(eb[1:0]));
                  if (s_axi_bready) void'(exp_b_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_r(input logic [7:0] id, input logic [63:0] data, input logic [1:0] resp,
                         input logic last);
      exp_r_q.push_back({id, data, resp, last});
   endtask

   task automatic wait_b_done();
      int n = 0;
      while (exp_b_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("b_drain", 64'(exp_b_q.size()), 64'd0);
   endtask

   task automatic wait_r_done();
      int n = 0;
      while (exp_r_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("r_drain", 64'(exp_r_q.size()), 64'd0);
   endtask

   task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input int nbeats, input logic [7:0] strb, input logic [1:0] resp);
      int n;
      exp_b_q.push_back({id, resp});
      @(negedge clk);
      s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
      s_axi_awsize = 3'd3; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
      n = 0;
      while (!s_axi_awready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("aw_accept", 64'(s_axi_awready), 64'd1);
      @(posedge clk);
      #1 s_axi_awvalid = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         @(negedge clk);
         s_axi_wdata = wd[i]; s_axi_wstrb = strb;
         s_axi_wlast = (i == nbeats - 1); s_axi_wvalid = 1'b1;
         n = 0;
         while (!s_axi_wready && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("w_accept", 64'(s_axi_wready), 64'd1);
         @(posedge clk);
         #1 s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      end
      wait_b_done();
   endtask

   task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
      int n;
      @(negedge clk);
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
      s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("ar_accept", 64'(s_axi_arready), 64'd1);
      @(posedge clk);
      #1 s_axi_arvalid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      rst_n = 1'b0;
      s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
      s_axi_arburst = '0; s_axi_arvalid = 1'b0;
      s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
      s_axi_awburst = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_arready", 64'(s_axi_arready), 64'd0);
      check("rst_awready", 64'(s_axi_awready), 64'd0);
      check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
      check("rst_wready", 64'(s_axi_wready), 64'd0);
      check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
      check("rst_rdata", s_axi_rdata, 64'd0);
      rst_n = 1'b1;
      check("arready_at_release", 64'(s_axi_arready), 64'd0);
      @(posedge clk);
      #1;
      check("arready_1cyc_after", 64'(s_axi_arready), 64'd1);
      check("awready_1cyc_after", 64'(s_axi_awready), 64'd1);

      // T1: 4-beat write, OKAY, bid echoes awid
      wd[0] = 64'd1; wd[1] = 64'd2; wd[2] = 64'd3; wd[3] = 64'd4;
      do_write(8'h5A, 32'h100, 8'd3, 4, 8'hFF, 2'b00);

      // T2: readback with 2-cycle latency, rlast on beat 4 only
      push_r(8'h3C, 64'd1, 2'b00, 1'b0);
      push_r(8'h3C, 64'd2, 2'b00, 1'b0);
      push_r(8'h3C, 64'd3, 2'b00, 1'b0);
      push_r(8'h3C, 64'd4, 2'b00, 1'b1);
      do_read(8'h3C, 32'h100, 8'd3);
      @(negedge clk);
      check("r_latency_cyc1", 64'(s_axi_rvalid), 64'd0);
      @(negedge clk);
      check("r_latency_cyc2", 64'(s_axi_rvalid), 64'd1);
      wait_r_done();

      // T3: 8-beat read with rready toggling; monitor checks held data while stalled
      for (int i = 0; i < 8; i++) wd[i] = 64'hA5A5_0000_0000_0010 + 64'(i);
      do_write(8'h01, 32'h200, 8'd7, 8, 8'hFF, 2'b00);
      for (int i = 0; i < 8; i++) push_r(8'h02, 64'hA5A5_0000_0000_0010 + 64'(i), 2'b00, i == 7);
      rmode = 1;
      do_read(8'h02, 32'h200, 8'd7);
      wait_r_done();
      rmode = 0;

      // T4: partial strobe over all-ones word
      wd[0] = '1;
      do_write(8'h03, 32'h300, 8'd0, 1, 8'hFF, 2'b00);
      wd[0] = '0;
      do_write(8'h04, 32'h300, 8'd0, 1, 8'h0F, 2'b00);
      push_r(8'h05, 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1);
      do_read(8'h05, 32'h300, 8'd0);
      wait_r_done();

      // T5: early wlast -> SLVERR, only the two sent beats land
      wd[0] = 64'hE0; wd[1] = 64'hE1; wd[2] = 64'hE2; wd[3] = 64'hE3;
      do_write(8'h06, 32'h400, 8'd3, 4, 8'hFF, 2'b00);
      wd[0] = 64'h11; wd[1] = 64'h22;
      do_write(8'h07, 32'h400, 8'd3, 2, 8'hFF, 2'b10);
      push_r(8'h08, 64'h11, 2'b00, 1'b0);
      push_r(8'h08, 64'h22, 2'b00, 1'b0);
      push_r(8'h08, 64'hE2, 2'b00, 1'b0);
      push_r(8'h08, 64'hE3, 2'b00, 1'b1);
      do_read(8'h08, 32'h400, 8'd3);
      wait_r_done();

      // Late wlast: beat past len is acked but dropped, SLVERR
      wd[0] = 64'hC0; wd[1] = 64'hC1; wd[2] = 64'hC2;
      do_write(8'h09, 32'h500, 8'd2, 3, 8'hFF, 2'b00);
      wd[0] = 64'hD0; wd[1] = 64'hD1; wd[2] = 64'hD2;
      do_write(8'h0A, 32'h500, 8'd1, 3, 8'hFF, 2'b10);
      push_r(8'h0B, 64'hD0, 2'b00, 1'b0);
      push_r(8'h0B, 64'hD1, 2'b00, 1'b0);
      push_r(8'h0B, 64'hC2, 2'b00, 1'b1);
      do_read(8'h0B, 32'h500, 8'd2);
      wait_r_done();

      // Burst wraps from word 1023 to word 0
      wd[0] = 64'h77; wd[1] = 64'h88;
      do_write(8'h0C, 32'h1FF8, 8'd1, 2, 8'hFF, 2'b00);
      push_r(8'h0D, 64'h77, 2'b00, 1'b0);
      push_r(8'h0D, 64'h88, 2'b00, 1'b1);
      do_read(8'h0D, 32'h1FF8, 8'd1);
      wait_r_done();
      push_r(8'h0E, 64'h88, 2'b00, 1'b1);
      do_read(8'h0E, 32'h0, 8'd0);
      wait_r_done();

`ifdef AXI_MEM_SLAVE_RANGE_CHK_EN
      // T6: out-of-range read and suppressed out-of-range write
      push_r(8'h0F, 64'h0, 2'b10, 1'b0);
      push_r(8'h0F, 64'h0, 2'b10, 1'b1);
      do_read(8'h0F, 32'h0010_0000, 8'd1);
      wait_r_done();
      wd[0] = 64'h99;
      do_write(8'h10, 32'h0010_0000, 8'd0, 1, 8'hFF, 2'b10);
      push_r(8'h11, 64'h88, 2'b00, 1'b1);
      do_read(8'h11, 32'h0, 8'd0);
      wait_r_done();
`else
      // Upper address bits ignored: 0x10000 aliases word 0
      push_r(8'h0F, 64'h88, 2'b00, 1'b1);
      do_read(8'h0F, 32'h0001_0000, 8'd0);
      wait_r_done();
`endif

      // Reset mid-read: rvalid drops at once, no response afterwards
      for (int i = 0; i < 8; i++) push_r(8'h12, 64'hA5A5_0000_0000_0010 + 64'(i), 2'b00, i == 7);
      rmode = 2;
      do_read(8'h12, 32'h200, 8'd7);
      n = 0;
      while (!s_axi_rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("midread_rvalid_up", 64'(s_axi_rvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("abort_rvalid", 64'(s_axi_rvalid), 64'd0);
      check("abort_arready", 64'(s_axi_arready), 64'd0);
      check("abort_rdata", s_axi_rdata, 64'd0);
      exp_r_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      rmode = 0;
      repeat (4) @(negedge clk);
      check("post_abort_rvalid", 64'(s_axi_rvalid), 64'd0);
      check("post_abort_arready", 64'(s_axi_arready), 64'd1);

      // SRAM survives reset
      push_r(8'h13, 64'd1, 2'b00, 1'b1);
      do_read(8'h13, 32'h100, 8'd0);
      wait_r_done();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
